// File: rtl/cr_su_hb_capture_ctl.sv
// ---------------------------------------------------------------------------
// cr_su_hb_capture_ctl
// Sequencer for the SU history buffer. Trace words are recorded into a
// circular buffer while armed. A trigger starts an optional post-trigger
// window; when that window closes the buffer freezes. The frozen contents are
// presented oldest-first for regfile readout until a rearm strobe arrives.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   cfg_enable_i    capture enable level; low forces IDLE
//   cfg_post_i      post-trigger word count, sampled when a trigger is accepted
//   trace_vld_i     trace word valid
//   trace_data_i    trace word
//   trig_i          trigger pulse
//   rearm_i         rearm strobe, only honoured in FROZEN
//   su_hb_o         buffer view; entry k at [k*ENTRY_W +: ENTRY_W], k=0 oldest
//   hb_state_o      0 IDLE, 1 RECORD, 2 POST, 3 FROZEN
//   hb_fill_o       number of valid entries
//   hb_frozen_o     high while FROZEN
//   trig_cnt_o      accepted triggers (saturating)
//   trig_ign_o      triggers ignored in IDLE/POST/FROZEN (saturating)
// ---------------------------------------------------------------------------
module cr_su_hb_capture_ctl #(
    parameter int N_ENTRIES = 8,
    parameter int ENTRY_W   = 108,
    parameter int CNT_W     = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_enable_i,
    input  logic [2:0]                     cfg_post_i,
    input  logic                           trace_vld_i,
    input  logic [ENTRY_W-1:0]             trace_data_i,
    input  logic                           trig_i,
    input  logic                           rearm_i,
    output logic [N_ENTRIES*ENTRY_W-1:0]   su_hb_o,
    output logic [1:0]                     hb_state_o,
    output logic [$clog2(N_ENTRIES):0]     hb_fill_o,
    output logic                           hb_frozen_o,
    output logic [CNT_W-1:0]               trig_cnt_o,
    output logic [CNT_W-1:0]               trig_ign_o
);

    localparam int PTR_W  = $clog2(N_ENTRIES);
    localparam int FILL_W = PTR_W + 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(N_ENTRIES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_POST   = 2'd2,
        ST_FROZEN = 2'd3
    } state_t;

    state_t                   r_state, w_state_next;
    logic [ENTRY_W-1:0]       r_buf [N_ENTRIES];
    logic [PTR_W-1:0]         r_wr_ptr, w_wr_ptr_next;
    logic [FILL_W-1:0]        r_fill, w_fill_next;
    logic [2:0]               r_post_cnt, w_post_cnt_next;
    logic [N_ENTRIES*ENTRY_W-1:0] r_su_hb;
    logic                     r_frozen;
    logic [CNT_W-1:0]         r_trig_cnt, r_trig_ign;

    logic                     w_wr_en;
    logic                     w_trig_acc;
    logic                     w_trig_ign;
    logic [ENTRY_W-1:0]       w_buf_next [N_ENTRIES];
    logic [PTR_W-1:0]         w_rd_idx   [N_ENTRIES];
    logic [N_ENTRIES*ENTRY_W-1:0] w_hb_view;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; disable overrides everything else
    always_comb begin
        w_state_next = r_state;
        if (!cfg_enable_i) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   w_state_next = ST_RECORD;
                ST_RECORD: if (trig_i) w_state_next = (cfg_post_i == 3'd0) ? ST_FROZEN : ST_POST;
                ST_POST:   if (trace_vld_i && r_post_cnt == 3'd1) w_state_next = ST_FROZEN;
                ST_FROZEN: if (rearm_i) w_state_next = ST_RECORD;
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    // Datapath controls derived from the current state
    always_comb begin
        w_wr_en    = cfg_enable_i && trace_vld_i && (r_state == ST_RECORD || r_state == ST_POST);
        w_trig_acc = cfg_enable_i && trig_i && (r_state == ST_RECORD);
        // Ignored triggers are classified by state alone, so a trigger that
        // coincides with a rearm in FROZEN lands here.
        w_trig_ign = trig_i && (r_state != ST_RECORD);

        w_wr_ptr_next = r_wr_ptr + PTR_W'(w_wr_en);
        w_fill_next   = (w_wr_en && r_fill != FILL_MAX) ? r_fill + FILL_W'(1) : r_fill;
        if (!cfg_enable_i || r_state == ST_IDLE || (r_state == ST_FROZEN && rearm_i)) begin
            w_wr_ptr_next = '0;
            w_fill_next   = '0;
        end

        w_post_cnt_next = r_post_cnt;
        if (!cfg_enable_i) begin
            w_post_cnt_next = '0;
        end else if (w_trig_acc) begin
            w_post_cnt_next = cfg_post_i;
        end else if (r_state == ST_POST && trace_vld_i) begin
            w_post_cnt_next = r_post_cnt - 3'd1;
        end
    end

    // Buffer view is built from post-write values so the registered output
    // shows a write one cycle after it happens.
    genvar gi;
    generate
        for (gi = 0; gi < N_ENTRIES; gi++) begin : g_view
            assign w_buf_next[gi] = (w_wr_en && r_wr_ptr == PTR_W'(gi)) ? trace_data_i : r_buf[gi];
            // fill==N wraps to 0 in PTR_W bits, giving oldest = wr_ptr
            assign w_rd_idx[gi]   = w_wr_ptr_next - w_fill_next[PTR_W-1:0] + PTR_W'(gi);
            assign w_hb_view[gi*ENTRY_W +: ENTRY_W] =
                (FILL_W'(gi) < w_fill_next) ? w_buf_next[w_rd_idx[gi]] : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ENTRIES; i++) r_buf[i] <= '0;
            r_wr_ptr   <= '0;
            r_fill     <= '0;
            r_post_cnt <= '0;
            r_su_hb    <= '0;
            r_frozen   <= 1'b0;
            r_trig_cnt <= '0;
            r_trig_ign <= '0;
        end else begin
            if (w_wr_en) r_buf[r_wr_ptr] <= trace_data_i;
            r_wr_ptr   <= w_wr_ptr_next;
            r_fill     <= w_fill_next;
            r_post_cnt <= w_post_cnt_next;
            r_frozen   <= (w_state_next == ST_FROZEN);
            // The view holds its last contents while idle
            if (w_state_next != ST_IDLE) r_su_hb <= w_hb_view;
            if (w_trig_acc && r_trig_cnt != '1) r_trig_cnt <= r_trig_cnt + CNT_W'(1);
            if (w_trig_ign && r_trig_ign != '1) r_trig_ign <= r_trig_ign + CNT_W'(1);
        end
    end

    // Output assignments
    always_comb begin
        su_hb_o     = r_su_hb;
        hb_state_o  = r_state;
        hb_fill_o   = r_fill;
        hb_frozen_o = r_frozen;
        trig_cnt_o  = r_trig_cnt;
        trig_ign_o  = r_trig_ign;
    end

endmodule
